// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned BE_W       = 4;

    localparam logic [BE_W-1:0] WE_READ = 4'b0000;

    // Owner of an in-flight memory access, used to route read data back.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

endpackage

// File: rtl/rsp_tag_pipe.sv
// Fixed-depth shift register of owner tags aligned with the memory read latency.
module rsp_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst_n,
    input  owner_t tag_in,
    output owner_t tag_out
);

    localparam int unsigned TW = $bits(owner_t);

    logic [DEPTH*TW-1:0] tag_q;

    // Shift tags toward the output; flush drops every in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= {DEPTH{OWN_NONE}};
        end else begin
            tag_q <= {tag_q[(DEPTH-1)*TW-1:0], tag_in};
        end
    end

    assign tag_out = owner_t'(tag_q[DEPTH*TW-1 -: TW]);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between instruction fetch and data access.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned MEM_LAT      = 1,
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [BE_W-1:0]   d_we,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic [BE_W-1:0]   mem_write,
    output logic [DATA_W-1:0] mem_data_w,
    input  logic [DATA_W-1:0] mem_data_r
);

    localparam int unsigned STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam int unsigned PIPE_D   = 1 + MEM_LAT;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    logic [STREAK_W-1:0] streak_q;
    logic                streak_full;
    logic                d_is_read;
    owner_t              tag_in;
    owner_t              tag_out;

    // Grant selection: data wins unless it has starved a pending fetch too long.
    always_comb begin
        streak_full = (streak_q == STREAK_MAX);
        d_is_read   = (d_we == WE_READ);
        i_gnt       = 1'b0;
        d_gnt       = 1'b0;
        tag_in      = OWN_NONE;
        if (rst) begin
            if (d_req && (!i_req || !streak_full)) begin
                d_gnt = 1'b1;
            end else if (i_req) begin
                i_gnt = 1'b1;
            end
        end
        if (i_gnt) begin
            tag_in = OWN_I;
        end else if (d_gnt && d_is_read) begin
            tag_in = OWN_D;
        end
    end

    // Count consecutive data grants that bypass a waiting fetch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak_q <= '0;
        end else if (!i_req || i_gnt) begin
            streak_q <= '0;
        end else if (d_gnt && !streak_full) begin
            streak_q <= streak_q + STREAK_W'(1);
        end
    end

    // Register the accepted access onto the memory port for one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_addr   <= '0;
            mem_read   <= 1'b0;
            mem_write  <= WE_READ;
            mem_data_w <= '0;
        end else begin
            mem_read  <= 1'b0;
            mem_write <= WE_READ;
            if (i_gnt) begin
                mem_addr <= i_addr;
                mem_read <= 1'b1;
            end else if (d_gnt) begin
                mem_addr   <= d_addr;
                mem_read   <= d_is_read;
                mem_write  <= d_we;
                mem_data_w <= d_wdata;
            end
        end
    end

    rsp_tag_pipe #(
        .DEPTH (PIPE_D)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // Route returning read data to the owner of the oldest access.
    always_comb begin
        i_rvalid = (tag_out == OWN_I);
        d_rvalid = (tag_out == OWN_D);
        i_rdata  = i_rvalid ? mem_data_r : '0;
        d_rdata  = d_rvalid ? mem_data_r : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus, decoupled monitors.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, d_req;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_we;
    logic        i_gnt, d_gnt, i_rvalid, d_rvalid;
    logic [31:0] i_rdata, d_rdata;
    logic [31:0] mem_addr, mem_data_w;
    logic        mem_read;
    logic [3:0]  mem_write;
    logic [31:0] mem_data_r = 32'h0;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          is_d;
        logic [31:0] data;
        string       nm;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic [3:0]  we;
        logic [31:0] wd;
        bit          chk_wd;
        string       nm;
    } mexp_t;

    rsp_t  rsp_q[$];
    mexp_t mem_q[$];
    logic [31:0] last_addr = 32'h0;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MAX_D_STREAK(4)
    ) dut (
        .clk(clk), .rst(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_data_w(mem_data_w), .mem_data_r(mem_data_r)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [31:0] a);
        case (a)
            32'h10:  model = 32'hDEADBEEF;
            32'h40:  model = 32'hAAAA0000;
            32'h44:  model = 32'hBBBB0000;
            default: model = {a[15:0], ~a[15:0]};
        endcase
    endfunction

    // One-cycle-latency memory model.
    always @(posedge clk) begin
        if (mem_read) mem_data_r <= model(mem_addr);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Check expected grants this cycle and queue the expected memory issue and read return.
    task automatic arb(input bit ei, input bit ed, input string nm);
        mexp_t m;
        rsp_t  r;
        @(negedge clk);
        chk({nm, ".i_gnt"}, 64'(i_gnt), 64'(ei));
        chk({nm, ".d_gnt"}, 64'(d_gnt), 64'(ed));
        m.nm = nm;
        m.wd = 32'h0;
        m.chk_wd = 1'b0;
        if (ei) begin
            r.is_d = 1'b0; r.data = model(i_addr); r.nm = nm;
            rsp_q.push_back(r);
            m.addr = i_addr; m.rd = 1'b1; m.we = 4'b0000;
            last_addr = i_addr;
        end else if (ed) begin
            if (d_we == 4'b0000) begin
                r.is_d = 1'b1; r.data = model(d_addr); r.nm = nm;
                rsp_q.push_back(r);
            end
            m.addr = d_addr; m.rd = (d_we == 4'b0000); m.we = d_we;
            m.wd = d_wdata; m.chk_wd = (d_we != 4'b0000);
            last_addr = d_addr;
        end else begin
            m.addr = last_addr; m.rd = 1'b0; m.we = 4'b0000;
        end
        mem_q.push_back(m);
        @(posedge clk);
        #1;
    endtask

    // Memory-port monitor: one cycle after each arbitration decision.
    initial begin
        mexp_t m;
        forever begin
            @(posedge clk);
            #2;
            if (mem_q.size() > 0) begin
                m = mem_q.pop_front();
                chk({m.nm, ".mem_addr"},  64'(mem_addr),  64'(m.addr));
                chk({m.nm, ".mem_read"},  64'(mem_read),  64'(m.rd));
                chk({m.nm, ".mem_write"}, 64'(mem_write), 64'(m.we));
                if (m.chk_wd) chk({m.nm, ".mem_data_w"}, 64'(mem_data_w), 64'(m.wd));
            end
        end
    end

    // Response monitor: pops the scoreboard whenever either port presents rvalid.
    initial begin
        rsp_t r;
        forever begin
            @(negedge clk);
            if (i_rvalid || d_rvalid) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_rvalid", 64'({i_rvalid, d_rvalid}), 64'(0));
                end else begin
                    r = rsp_q.pop_front();
                    chk({r.nm, ".rvalid_port"}, 64'({i_rvalid, d_rvalid}),
                        r.is_d ? 64'(2'b01) : 64'(2'b10));
                    chk({r.nm, ".rdata"}, r.is_d ? 64'(d_rdata) : 64'(i_rdata), 64'(r.data));
                end
            end
            if (!i_rvalid) chk("i_rdata_gated", 64'(i_rdata), 64'(0));
            if (!d_rvalid) chk("d_rdata_gated", 64'(d_rdata), 64'(0));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit seq_d[10]  = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        bit seq2_d[9]  = '{1, 1, 1, 1, 1, 1, 1, 1, 0};

        // Reset with both requesters active.
        rst_n = 1'b0; i_req = 1'b1; d_req = 1'b1;
        i_addr = 32'h200; d_addr = 32'h100; d_we = 4'b0000; d_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.i_gnt", 64'(i_gnt), 64'(0));
        chk("rst.d_gnt", 64'(d_gnt), 64'(0));
        chk("rst.mem_read", 64'(mem_read), 64'(0));
        chk("rst.mem_write", 64'(mem_write), 64'(0));
        chk("rst.mem_addr", 64'(mem_addr), 64'(0));
        chk("rst.mem_data_w", 64'(mem_data_w), 64'(0));
        chk("rst.rvalid", 64'({i_rvalid, d_rvalid}), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        arb(0, 1, "rst_first");
        i_req = 1'b0; d_req = 1'b0;
        repeat (3) arb(0, 0, "idle");

        // Single fetch.
        i_req = 1'b1; i_addr = 32'h10;
        arb(1, 0, "fetch");
        i_req = 1'b0;
        repeat (3) arb(0, 0, "idle");

        // Data write.
        d_req = 1'b1; d_we = 4'b0011; d_addr = 32'h20; d_wdata = 32'h12345678;
        arb(0, 1, "write");
        d_req = 1'b0; d_we = 4'b0000;
        repeat (3) arb(0, 0, "idle");

        // Sustained contention.
        i_req = 1'b1; d_req = 1'b1; i_addr = 32'h300; d_addr = 32'h400; d_wdata = 32'h0;
        for (int k = 0; k < 10; k++) arb(!seq_d[k], seq_d[k], $sformatf("cont%0d", k));
        i_req = 1'b0; d_req = 1'b0;
        repeat (3) arb(0, 0, "idle");

        // Streak clears when the fetch request drops.
        i_addr = 32'h500; d_addr = 32'h600;
        for (int k = 0; k < 9; k++) begin
            i_req = (k != 3); d_req = 1'b1;
            arb(!seq2_d[k], seq2_d[k], $sformatf("sclr%0d", k));
        end
        i_req = 1'b0; d_req = 1'b0;
        repeat (3) arb(0, 0, "idle");

        // Back-to-back reads to different owners.
        i_req = 1'b1; i_addr = 32'h40;
        arb(1, 0, "b2b_i");
        i_req = 1'b0; d_req = 1'b1; d_addr = 32'h44;
        arb(0, 1, "b2b_d");
        d_req = 1'b0;
        repeat (3) arb(0, 0, "idle");

        // Reset while a fetch is in flight.
        i_req = 1'b1; i_addr = 32'h50;
        @(negedge clk);
        chk("rmid.i_gnt", 64'(i_gnt), 64'(1));
        @(posedge clk); #1;
        chk("rmid.mem_read_pre", 64'(mem_read), 64'(1));
        chk("rmid.mem_addr_pre", 64'(mem_addr), 64'(32'h50));
        rst_n = 1'b0;
        #1;
        chk("rmid.mem_read_rst", 64'(mem_read), 64'(0));
        chk("rmid.mem_addr_rst", 64'(mem_addr), 64'(0));
        chk("rmid.i_gnt_rst", 64'(i_gnt), 64'(0));
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rmid.i_rvalid", 64'(i_rvalid), 64'(0));
        chk("rmid.i_gnt_hold", 64'(i_gnt), 64'(0));
        @(posedge clk); #1;
        i_req = 1'b0;
        rst_n = 1'b1;
        last_addr = 32'h0;
        repeat (4) arb(0, 0, "post_rst");

        chk("rsp_drain", 64'(rsp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares one single-port `ram` instance between the CPU instruction-fetch port and data-access port. It sits between `CPU` and a unified memory and replaces the split instruction/data memories. Each cycle it accepts at most one access, registers it onto the memory port, and routes read data back to the issuing requester. Data accesses have priority, and a streak limit prevents instruction-fetch starvation.

## Interface

Parameters:

- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MEM_LAT`, 1, cycles from `mem_read` high to `mem_data_r` valid (≥1)
- `MAX_D_STREAK`, 4, maximum number of consecutive data grants while an instruction request is pending (≥1)

Ports:

- `clk` in 1: single clock; all state updates on the rising edge
- `rst` in 1: reset is asynchronous and active-low
- `i_req` in 1: instruction read request; held with `i_addr` until granted
- `i_addr` in ADDR_W: instruction address
- `i_gnt` out 1: instruction request accepted this cycle
- `i_rvalid` out 1: `i_rdata` valid this cycle
- `i_rdata` out DATA_W: instruction read data
- `d_req` in 1: data request; held with its payload until granted
- `d_addr` in ADDR_W: data address
- `d_we` in 4: byte write enables; 4'b0000 means read
- `d_wdata` in DATA_W: write data
- `d_gnt` out 1: data request accepted this cycle
- `d_rvalid` out 1: `d_rdata` valid this cycle
- `d_rdata` out DATA_W: data read data
- `mem_addr` out ADDR_W: registered memory address
- `mem_read` out 1: registered read strobe
- `mem_write` out 4: registered byte write enables
- `mem_data_w` out DATA_W: registered write data
- `mem_data_r` in DATA_W: memory read data

## Operation

- Acceptance: a transfer is accepted in a cycle where `req` and `gnt` are both high. `gnt` is combinational from the `req` inputs and the streak state. At most one `gnt` is high per cycle.
- Arbitration order:
  - Only one requester active: that requester is granted.
  - Both active and `streak < MAX_D_STREAK`: data is granted.
  - Both active and `streak == MAX_D_STREAK`: instruction is granted.
- Streak counter, width clog2(MAX_D_STREAK+1):
  - Increments on a data grant while `i_req` is high.
  - Clears to 0 on an instruction grant, or in any cycle where `i_req` is low.
  - Never exceeds `MAX_D_STREAK`.
- Issue: the accepted access is registered onto `mem_*` for exactly one cycle.
  - `mem_read` = 1 for instruction fetches and for data reads.
  - `mem_write` = `d_we` for data writes.
  - `mem_read` and `mem_write` are never nonzero together.
- Idle cycle (no grant): `mem_read`=0 and `mem_write`=0. `mem_addr` and `mem_data_w` hold their last values.
- Return routing: each read pushes an owner tag (NONE/I/D) into a (1+MEM_LAT)-deep tag pipe. When the tag reaches the end of the pipe:
  - The owner's `rvalid` pulses for one cycle.
  - The owner's `rdata` = `mem_data_r`.
  - The other port's `rvalid` stays 0.
- Writes push tag NONE and never produce `rvalid`.
- Responses return in issue order. Throughput is one access per cycle sustained.
- Reset (`rst` low, any time, including mid-transaction):
  - All outputs go to 0: `gnt`, `rvalid`, `rdata`, `mem_*`.
  - Streak is cleared and the tag pipe is flushed to NONE.
  - In-flight reads are dropped and produce no `rvalid` after release.
- While `rst` is low, `gnt` stays 0 even if requests are present.

## Timing

- Cycle T: request accepted (`gnt`=1).
- Cycle T+1: `mem_*` carries the access.
- Cycle T+1+MEM_LAT: `rvalid`=1 and `rdata` valid. With the default MEM_LAT=1, this is T+2.
- `rdata` is a combinational mux of `mem_data_r`, gated to 0 when `rvalid`=0.
- A requester may raise `req` again in T+1; the new request is arbitrated normally.

## Structure

- Package `mem_arb_pkg` holds:
  - The owner enum: `OWN_NONE`, `OWN_I`, `OWN_D`.
  - Default `ADDR_W`/`DATA_W` constants.
  - The `WE_READ` = 4'b0000 constant.
- One sub-module, `rsp_tag_pipe`: a parameterised-depth shift register of owner tags, with async active-low flush.
- Grant logic, streak counter and the `mem_*` output registers live in the top module.

## Test plan

- Reset:
  - Assert `rst`=0 with both `req` high.
  - Required: all outputs 0 and both `gnt`=0.
  - After release, the first grant goes to data.
- Single fetch:
  - `i_req` with `i_addr`=0x10; memory model returns 0xDEADBEEF.
  - Required: `i_gnt` at T; `mem_addr`=0x10 and `mem_read`=1 at T+1; `i_rvalid`=1 and `i_rdata`=0xDEADBEEF at T+2.
  - `d_rvalid` stays 0 throughout.
- Data write:
  - `d_we`=4'b0011, `d_addr`=0x20, `d_wdata`=0x12345678.
  - Required: at T+1 `mem_write`=4'b0011, `mem_data_w`=0x12345678, `mem_read`=0.
  - No `rvalid` on either port.
- Contention:
  - Both `req` held high for 10 cycles, MAX_D_STREAK=4.
  - Required grant sequence: D,D,D,D,I,D,D,D,D,I.
- Back-to-back reads:
  - I read 0x40, then a D read of 0x44 in the next cycle; memory returns 0xAAAA0000 and 0xBBBB0000.
  - Required: `i_rvalid` with 0xAAAA0000 at T+2, then `d_rvalid` with 0xBBBB0000 at T+3; no cross-routing.
- Reset mid-flight:
  - Pull `rst` low in T+1 after an I grant, release at T+3.
  - Required: `i_rvalid` never pulses, and `mem_read`=0 immediately when `rst` falls.
